// File: rtl/rfphoenix_mc_vec_issue_pkg.sv
// Shared rfPhoenix types used by the multicycle vector ALU issue/collect front end.
// Holds the issue FSM state enum and the default ALU latency.
package rfPhoenixPkg;

  localparam int MC_VEC_LAT = 10;
  localparam int NLANES     = 4;

  typedef logic [2:0]  tid_t;
  typedef logic [31:0] value_t;
  typedef value_t [NLANES-1:0] vector_value_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [5:0] rt;
    logic [5:0] ra;
    logic [5:0] rb;
    logic [5:0] rc;
  } instruction_t;

  typedef struct packed {
    logic          v;
    tid_t          tid;
    vector_value_t res;
  } pipeline_reg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } mc_issue_state_t;

endpackage

// File: rtl/rfphoenix_mc_vec_issue.sv
// Issue/collect front end for the multicycle vector ALU: holds operands, waits latency + done,
// hands the result to writeback. Optional watchdog: define RFPHOENIX_MC_ISSUE_TIMEOUT_EN.
module rfphoenix_mc_vec_issue
  import rfPhoenixPkg::*;
#(
  parameter int MC_LAT  = MC_VEC_LAT,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  instruction_t  req_ir,
  input  vector_value_t req_a,
  input  vector_value_t req_b,
  input  vector_value_t req_c,
  input  value_t        req_imm,
  input  pipeline_reg_t req_pr,
  input  tid_t          req_tid,
  output instruction_t  alu_ir,
  output vector_value_t alu_a,
  output vector_value_t alu_b,
  output vector_value_t alu_c,
  output value_t        alu_imm,
  output pipeline_reg_t alu_pr,
  input  pipeline_reg_t alu_o,
  input  logic          alu_done,
  output logic          wb_valid,
  input  logic          wb_ready,
  output pipeline_reg_t wb_pr,
  output tid_t          wb_tid,
  input  logic          flush,
  input  tid_t          flush_tid,
  output logic          busy,
  output logic          timeout_err
);

  // One counter width serves both the latency count and the watchdog.
  localparam int CNT_MAX = (MC_LAT > TIMEOUT + 2) ? MC_LAT : TIMEOUT + 2;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LOAD = cnt_t'(MC_LAT - 1);

  mc_issue_state_t state;
  cnt_t            cnt;
  logic            kill;
  tid_t            hold_tid;

  logic accept;
  logic held_flush;
  logic req_flush;
  logic cnt_zero;
  logic capture;

  // Writeback can retire and refill in the same cycle, hence the wb_ready path.
  assign req_ready  = (state == IDLE) || ((state == RESULT) && wb_ready);
  assign accept     = req_valid && req_ready;
  assign held_flush = flush && (flush_tid == hold_tid);
  assign req_flush  = flush && (flush_tid == req_tid);
  assign cnt_zero   = (cnt == '0);

`ifdef RFPHOENIX_MC_ISSUE_TIMEOUT_EN
  // The first stalled edge is the missed capture; TIMEOUT further stalled cycles are tolerated.
  localparam cnt_t WD_LIMIT = cnt_t'(TIMEOUT + 1);
  cnt_t wd_cnt;
  logic wd_fire;
  assign wd_fire = (state == RUN) && cnt_zero && !alu_done && (wd_cnt == WD_LIMIT);
  assign capture = cnt_zero && (alu_done || wd_fire);
`else
  assign capture     = cnt_zero && alu_done;
  assign timeout_err = 1'b0;
`endif

  // NOTE: all state below is sequential, so it is written with <= only; blocking
  // assignments here would make the update order depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      kill     <= 1'b0;
      hold_tid <= '0;
      busy     <= 1'b0;
      alu_ir   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_c    <= '0;
      alu_imm  <= '0;
      alu_pr   <= '0;
      wb_valid <= 1'b0;
      wb_pr    <= '0;
      wb_tid   <= '0;
`ifdef RFPHOENIX_MC_ISSUE_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is only possible from IDLE or from a completing RESULT handshake.
      state    <= RUN;
      busy     <= 1'b1;
      cnt      <= CNT_LOAD;
      kill     <= req_flush;
      hold_tid <= req_tid;
      alu_ir   <= req_ir;
      alu_a    <= req_a;
      alu_b    <= req_b;
      alu_c    <= req_c;
      alu_imm  <= req_imm;
      alu_pr   <= req_pr;
      wb_valid <= 1'b0;
`ifdef RFPHOENIX_MC_ISSUE_TIMEOUT_EN
      wd_cnt   <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (!cnt_zero) cnt <= cnt - cnt_t'(1);
          if (held_flush) kill <= 1'b1;
`ifdef RFPHOENIX_MC_ISSUE_TIMEOUT_EN
          if (cnt_zero && !alu_done && !wd_fire) wd_cnt <= wd_cnt + cnt_t'(1);
          if (wd_fire) timeout_err <= 1'b1;
`endif
          if (capture) begin
            wb_pr  <= alu_o;
            wb_tid <= hold_tid;
            if (kill || held_flush) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= RESULT;
              wb_valid <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (held_flush || wb_ready) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rfphoenix_mc_vec_issue.sv
// Directed bench for rfphoenix_mc_vec_issue: table-driven single ops plus hand-written
// back-to-back, flush, late-done and mid-operation reset sequences.
module tb_rfphoenix_mc_vec_issue;
  import rfPhoenixPkg::*;

  localparam int LAT = MC_VEC_LAT;
  typedef logic [131:0] word_t;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  instruction_t  req_ir;
  vector_value_t req_a;
  vector_value_t req_b;
  vector_value_t req_c;
  value_t        req_imm;
  pipeline_reg_t req_pr;
  tid_t          req_tid;
  instruction_t  alu_ir;
  vector_value_t alu_a;
  vector_value_t alu_b;
  vector_value_t alu_c;
  value_t        alu_imm;
  pipeline_reg_t alu_pr;
  pipeline_reg_t alu_o;
  logic          alu_done;
  logic          wb_valid;
  logic          wb_ready;
  pipeline_reg_t wb_pr;
  tid_t          wb_tid;
  logic          flush;
  tid_t          flush_tid;
  logic          busy;
  logic          timeout_err;

  rfphoenix_mc_vec_issue #(.MC_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ir(req_ir), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_imm(req_imm), .req_pr(req_pr), .req_tid(req_tid),
    .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_imm(alu_imm), .alu_pr(alu_pr),
    .alu_o(alu_o), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pr(wb_pr), .wb_tid(wb_tid),
    .flush(flush), .flush_tid(flush_tid),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic instruction_t ir_of(input tid_t t);
    return instruction_t'({8'h5a, 3'b000, t, 6'd1, 6'd2, 6'd3});
  endfunction

  function automatic vector_value_t vb_of(input vector_value_t a);
    return ~a;
  endfunction

  function automatic vector_value_t vc_of(input vector_value_t a);
    return {a[1], a[0], a[3], a[2]};
  endfunction

  function automatic value_t imm_of(input tid_t t);
    return 32'h1000_0000 | 32'(t);
  endfunction

  function automatic pipeline_reg_t pr_of(input tid_t t, input vector_value_t a);
    return {1'b1, t, a ^ {4{32'h0f0f_0f0f}}};
  endfunction

  function automatic pipeline_reg_t junk(input int k);
    return {1'b0, 3'(k), {4{32'hdead_0000 | 32'(k)}}};
  endfunction

  function automatic logic held_ok(input tid_t t, input vector_value_t a);
    return (alu_ir == ir_of(t)) && (alu_a == a) && (alu_b == vb_of(a)) &&
           (alu_c == vc_of(a)) && (alu_imm == imm_of(t)) && (alu_pr == pr_of(t, a));
  endfunction

  task automatic drive_req(input tid_t t, input vector_value_t a);
    req_valid = 1'b1;
    req_tid   = t;
    req_ir    = ir_of(t);
    req_a     = a;
    req_b     = vb_of(a);
    req_c     = vc_of(a);
    req_imm   = imm_of(t);
    req_pr    = pr_of(t, a);
  endtask

  // After the accept edge the request bus is scrambled so hold registers are exercised.
  task automatic drop_req();
    req_valid = 1'b0;
    req_tid   = req_tid + 3'd1;
    req_ir    = '0;
    req_a     = ~req_a;
    req_b     = '0;
    req_c     = '1;
    req_imm   = '1;
    req_pr    = '0;
  endtask

  task automatic wait_wb(input int limit, output int n);
    n = 0;
    while (wb_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    tid_t          tid;
    vector_value_t a;
    pipeline_reg_t res;
    int            stall;
    tid_t          exp_tid;
    pipeline_reg_t exp_pr;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int lat;
    logic ok;
    logic rdy_low;
    logic seen;
    logic ready11;
    logic busy11;
    logic busy12;
    pipeline_reg_t p1;
    pipeline_reg_t p2;

    vecs[0] = '{tid: 3'd3, a: {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444},
                res: {1'b1, 3'd3, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}, stall: 0,
                exp_tid: 3'd3, exp_pr: {1'b1, 3'd3, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210}};
    vecs[1] = '{tid: 3'd6, a: {32'hcafe_f00d, 32'h0000_0001, 32'h8000_0000, 32'h5555_aaaa},
                res: {1'b1, 3'd6, 128'hffff_0000_ffff_0000_1234_5678_9abc_def0}, stall: 5,
                exp_tid: 3'd6, exp_pr: {1'b1, 3'd6, 128'hffff_0000_ffff_0000_1234_5678_9abc_def0}};
    vecs[2] = '{tid: 3'd0, a: {32'h0, 32'hffff_ffff, 32'h0, 32'hffff_ffff},
                res: {1'b0, 3'd0, 128'h0000_0000_0000_0000_0000_0000_0000_00a5}, stall: 2,
                exp_tid: 3'd0, exp_pr: {1'b0, 3'd0, 128'h0000_0000_0000_0000_0000_0000_0000_00a5}};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_ir    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    req_imm   = '0;
    req_pr    = '0;
    req_tid   = '0;
    alu_o     = junk(0);
    alu_done  = 1'b1;
    wb_ready  = 1'b0;
    flush     = 1'b0;
    flush_tid = '0;

    // Reset state
    #7;
    check("rst_busy", word_t'(busy), word_t'(0));
    check("rst_wb_valid", word_t'(wb_valid), word_t'(0));
    check("rst_wb_pr", word_t'(wb_pr), word_t'(0));
    check("rst_alu_a", word_t'(alu_a), word_t'(0));
    check("rst_req_ready", word_t'(req_ready), word_t'(1));
    check("rst_timeout_err", word_t'(timeout_err), word_t'(0));
    #5 rst = 1'b1;
    tick();

    // Table-driven single ops with varying writeback stalls
    for (int i = 0; i < 3; i++) begin
      wb_ready = (vecs[i].stall == 0);
      drive_req(vecs[i].tid, vecs[i].a);
      tick();
      drop_req();
      ok      = 1'b1;
      rdy_low = 1'b1;
      lat     = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
        alu_o = (k == LAT) ? vecs[i].res : junk(k + i * 64);
        tick();
        if (wb_valid === 1'b1) lat = k;
        else begin
          if (req_ready !== 1'b0) rdy_low = 1'b0;
          if (!held_ok(vecs[i].tid, vecs[i].a) || busy !== 1'b1) ok = 1'b0;
        end
      end
      alu_o = junk(99);
      check($sformatf("vec%0d_latency", i), word_t'(lat), word_t'(LAT));
      check($sformatf("vec%0d_wb_tid", i), word_t'(wb_tid), word_t'(vecs[i].exp_tid));
      check($sformatf("vec%0d_wb_pr", i), word_t'(wb_pr), word_t'(vecs[i].exp_pr));
      check($sformatf("vec%0d_alu_held", i), word_t'(ok), word_t'(1));
      check($sformatf("vec%0d_ready_low_in_run", i), word_t'(rdy_low), word_t'(1));
      ok = 1'b1;
      for (int s = 0; s < vecs[i].stall; s++) begin
        tick();
        if (wb_valid !== 1'b1 || wb_pr !== vecs[i].exp_pr || wb_tid !== vecs[i].exp_tid ||
            req_ready !== 1'b0) ok = 1'b0;
      end
      check($sformatf("vec%0d_stall_stable", i), word_t'(ok), word_t'(1));
      wb_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_ready_on_wb_ready", i), word_t'(req_ready), word_t'(1));
      tick();
      check($sformatf("vec%0d_released_valid", i), word_t'(wb_valid), word_t'(0));
      check($sformatf("vec%0d_released_busy", i), word_t'(busy), word_t'(0));
      wb_ready = 1'b0;
    end

    // Back-to-back: second op accepted on the first result's handshake edge
    p1 = {1'b1, 3'd1, {4{32'h0b0b_0001}}};
    p2 = {1'b1, 3'd5, {4{32'h0b0b_0002}}};
    wb_ready = 1'b1;
    alu_o    = p1;
    drive_req(3'd1, {4{32'h0000_00a1}});
    tick();
    drop_req();
    wait_wb(40, n);
    check("b2b_first_latency", word_t'(n), word_t'(LAT));
    check("b2b_first_pr", word_t'(wb_pr), word_t'(p1));
    drive_req(3'd5, {4{32'h0000_00a2}});
    #1;
    check("b2b_ready_in_result", word_t'(req_ready), word_t'(1));
    tick();
    drop_req();
    alu_o = p2;
    check("b2b_accept_valid_drop", word_t'(wb_valid), word_t'(0));
    check("b2b_accept_held", word_t'(held_ok(3'd5, {4{32'h0000_00a2}})), word_t'(1));
    wait_wb(40, n);
    check("b2b_second_latency", word_t'(n), word_t'(LAT));
    check("b2b_second_tid", word_t'(wb_tid), word_t'(5));
    check("b2b_second_pr", word_t'(wb_pr), word_t'(p2));
    tick();

    // Non-matching flush during RUN has no effect
    alu_o = {1'b1, 3'd3, {4{32'h0c0c_0003}}};
    drive_req(3'd3, {4{32'h0000_00c3}});
    tick();
    drop_req();
    repeat (3) tick();
    flush = 1'b1;
    flush_tid = 3'd2;
    tick();
    flush = 1'b0;
    wait_wb(40, n);
    check("flush_other_latency", word_t'(n + 4), word_t'(LAT));
    check("flush_other_tid", word_t'(wb_tid), word_t'(3));
    tick();

    // Matching flush during RUN drops the result
    drive_req(3'd3, {4{32'h0000_00d3}});
    tick();
    drop_req();
    seen    = 1'b0;
    ready11 = 1'b0;
    busy11  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      flush     = (k == 4);
      flush_tid = 3'd3;
      tick();
      if (wb_valid !== 1'b0) seen = 1'b1;
      if (k == 11) begin
        ready11 = req_ready;
        busy11  = busy;
      end
    end
    flush = 1'b0;
    check("flush_run_no_valid", word_t'(seen), word_t'(0));
    check("flush_run_ready_c11", word_t'(ready11), word_t'(1));
    check("flush_run_idle_c11", word_t'(busy11), word_t'(0));

    // Matching flush while holding a result in RESULT, writeback stalled
    wb_ready = 1'b0;
    drive_req(3'd4, {4{32'h0000_00e4}});
    tick();
    drop_req();
    wait_wb(40, n);
    check("flush_result_latency", word_t'(n), word_t'(LAT));
    flush     = 1'b1;
    flush_tid = 3'd4;
    tick();
    flush = 1'b0;
    check("flush_result_valid", word_t'(wb_valid), word_t'(0));
    check("flush_result_idle", word_t'(busy), word_t'(0));

    // Flush coinciding with accept, matched against req_tid
    wb_ready = 1'b1;
    drive_req(3'd6, {4{32'h0000_00f6}});
    flush     = 1'b1;
    flush_tid = 3'd6;
    tick();
    flush = 1'b0;
    drop_req();
    seen = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (wb_valid !== 1'b0) seen = 1'b1;
    end
    check("flush_accept_no_valid", word_t'(seen), word_t'(0));
    check("flush_accept_idle", word_t'(busy), word_t'(0));

    // Late done: alu_done low through cycle 15
    p1 = {1'b1, 3'd2, {4{32'h1a7e_d0e0}}};
    alu_done = 1'b0;
    drive_req(3'd2, {4{32'h0000_0102}});
    tick();
    drop_req();
    lat    = -1;
    busy12 = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      alu_done = (k >= 16);
      alu_o    = (k == 16) ? p1 : junk(k + 200);
      tick();
      if (wb_valid === 1'b1) lat = k;
      if (k == 12) busy12 = busy;
    end
    alu_done = 1'b1;
    alu_o    = junk(300);
    check("late_done_latency", word_t'(lat), word_t'(16));
    check("late_done_pr", word_t'(wb_pr), word_t'(p1));
    check("late_done_busy_c12", word_t'(busy12), word_t'(1));
    check("late_done_no_timeout", word_t'(timeout_err), word_t'(0));
    tick();

    // Reset asserted mid-RUN
    drive_req(3'd7, {4{32'h0000_0777}});
    tick();
    drop_req();
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", word_t'(busy), word_t'(0));
    check("midrst_alu_a", word_t'(alu_a), word_t'(0));
    check("midrst_alu_pr", word_t'(alu_pr), word_t'(0));
    check("midrst_wb_pr", word_t'(wb_pr), word_t'(0));
    check("midrst_wb_tid", word_t'(wb_tid), word_t'(0));
    check("midrst_wb_valid", word_t'(wb_valid), word_t'(0));
    check("midrst_req_ready", word_t'(req_ready), word_t'(1));
    @(negedge clk);
    rst = 1'b1;
    p1 = {1'b1, 3'd1, {4{32'h5eed_0001}}};
    alu_o = p1;
    drive_req(3'd1, {4{32'h0000_0111}});
    tick();
    drop_req();
    wait_wb(40, n);
    check("post_rst_latency", word_t'(n), word_t'(LAT));
    check("post_rst_tid", word_t'(wb_tid), word_t'(1));
    check("post_rst_pr", word_t'(wb_pr), word_t'(p1));
    tick();
    check("post_rst_idle", word_t'(busy), word_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
